// File: rtl/ldsd_control_fsm.sv
// ldsd_control_fsm: fetch/decode/sequence controller for the LD/SD datapath.
// Fetches one instruction per pass over a req/ack port, decodes RV64 LD/SD
// (funct3 = 011), drives operand selects in EXEC/MEM and the memory strobes in
// MEM, then advances the PC and the retired count.
// Optional feature: define SKIP_ILLEGAL_EN to skip illegal (non-zero)
// instructions instead of halting; an all-zero instruction always halts.
module ldsd_control_fsm #(
    parameter int unsigned           PC_WIDTH      = 32,
    parameter logic [PC_WIDTH-1:0]   RESET_PC      = {PC_WIDTH{1'b0}},
    parameter int unsigned           FETCH_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic                instr_req,
    output logic [PC_WIDTH-1:0] instr_addr,
    input  logic                instr_ack,
    input  logic [31:0]         instr_data,
    output logic [5:0]          register_1,
    output logic [5:0]          register_2,
    output logic [11:0]         offset,
    output logic                ALUSrc,
    output logic [3:0]          ALU_CO,
    output logic                RegWrite,
    output logic                MemWrite,
    output logic                MemRead,
    output logic                MemReg,
    output logic                busy,
    output logic                halted,
    output logic                error,
    output logic [31:0]         retired
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    localparam logic [6:0]          OPC_LOAD     = 7'b0000011;
    localparam logic [6:0]          OPC_STORE    = 7'b0100011;
    localparam logic [2:0]          F3_DOUBLE    = 3'b011;
    localparam logic [7:0]          TIMEOUT_LAST = 8'(FETCH_TIMEOUT - 1);
    localparam logic [PC_WIDTH-1:0] PC_STEP      = PC_WIDTH'(3'd4);

    state_t              state_r;
    logic [PC_WIDTH-1:0] pc_r;
    logic [31:0]         ir_r;
    logic [31:0]         retired_r;
    logic [7:0]          wait_cnt_r;
    logic                is_store_r;
    logic                instr_req_r;
    logic [5:0]          register_1_r;
    logic [5:0]          register_2_r;
    logic [11:0]         offset_r;
    logic                alu_src_r;
    logic [3:0]          alu_co_r;
    logic                reg_write_r;
    logic                mem_write_r;
    logic                mem_read_r;
    logic                mem_reg_r;
    logic                busy_r;
    logic                halted_r;
    logic                error_r;

    // LD rd,imm(rs1): opcode LOAD with 64-bit width
    function automatic logic is_ld(input logic [31:0] ir);
        return (ir[6:0] == OPC_LOAD) && (ir[14:12] == F3_DOUBLE);
    endfunction

    // SD rs2,imm(rs1): opcode STORE with 64-bit width
    function automatic logic is_sd(input logic [31:0] ir);
        return (ir[6:0] == OPC_STORE) && (ir[14:12] == F3_DOUBLE);
    endfunction

    // Sequencer: state, PC, IR, counters and every registered output
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            pc_r         <= RESET_PC;
            ir_r         <= 32'd0;
            retired_r    <= 32'd0;
            wait_cnt_r   <= 8'd0;
            is_store_r   <= 1'b0;
            instr_req_r  <= 1'b0;
            register_1_r <= 6'd0;
            register_2_r <= 6'd0;
            offset_r     <= 12'd0;
            alu_src_r    <= 1'b0;
            alu_co_r     <= 4'd0;
            reg_write_r  <= 1'b0;
            mem_write_r  <= 1'b0;
            mem_read_r   <= 1'b0;
            mem_reg_r    <= 1'b0;
            busy_r       <= 1'b0;
            halted_r     <= 1'b0;
            error_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r     <= ST_FETCH;
                        instr_req_r <= 1'b1;
                        busy_r      <= 1'b1;
                        wait_cnt_r  <= 8'd0;
                    end else begin
                        state_r     <= ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    if (instr_ack) begin
                        ir_r        <= instr_data;
                        instr_req_r <= 1'b0;
                        wait_cnt_r  <= 8'd0;
                        state_r     <= ST_DECODE;
                    end else if (wait_cnt_r == TIMEOUT_LAST) begin
                        // Last permitted wait cycle expired: give up and halt
                        error_r     <= 1'b1;
                        instr_req_r <= 1'b0;
                        busy_r      <= 1'b0;
                        halted_r    <= 1'b1;
                        state_r     <= ST_HALT;
                    end else begin
                        wait_cnt_r  <= wait_cnt_r + 8'd1;
                    end
                end
                ST_DECODE: begin
                    if (is_ld(ir_r) || is_sd(ir_r)) begin
                        is_store_r   <= is_sd(ir_r);
                        register_1_r <= {1'b0, ir_r[19:15]};
                        register_2_r <= is_sd(ir_r) ? {1'b0, ir_r[24:20]} : {1'b0, ir_r[11:7]};
                        offset_r     <= is_sd(ir_r) ? {ir_r[31:25], ir_r[11:7]} : ir_r[31:20];
                        alu_src_r    <= 1'b1;
                        alu_co_r     <= 4'b0010;
                        state_r      <= ST_EXEC;
`ifdef SKIP_ILLEGAL_EN
                    end else if (ir_r != 32'd0) begin
                        // Skip the bad word and carry on with the next one
                        error_r      <= 1'b1;
                        pc_r         <= pc_r + PC_STEP;
                        instr_req_r  <= 1'b1;
                        wait_cnt_r   <= 8'd0;
                        state_r      <= ST_FETCH;
`endif
                    end else begin
                        error_r      <= 1'b1;
                        busy_r       <= 1'b0;
                        halted_r     <= 1'b1;
                        state_r      <= ST_HALT;
                    end
                end
                ST_EXEC: begin
                    // Strobes become visible during MEM, one cycle only
                    mem_read_r  <= ~is_store_r;
                    reg_write_r <= ~is_store_r;
                    mem_reg_r   <= ~is_store_r;
                    mem_write_r <= is_store_r;
                    state_r     <= ST_MEM;
                end
                ST_MEM: begin
                    mem_read_r   <= 1'b0;
                    reg_write_r  <= 1'b0;
                    mem_reg_r    <= 1'b0;
                    mem_write_r  <= 1'b0;
                    register_1_r <= 6'd0;
                    register_2_r <= 6'd0;
                    offset_r     <= 12'd0;
                    alu_src_r    <= 1'b0;
                    alu_co_r     <= 4'd0;
                    pc_r         <= pc_r + PC_STEP;
                    retired_r    <= retired_r + 32'd1;
                    instr_req_r  <= 1'b1;
                    wait_cnt_r   <= 8'd0;
                    state_r      <= ST_FETCH;
                end
                ST_HALT: begin
                    state_r <= ST_HALT;
                end
                default: begin
                    // Unreachable encoding: fail safe into HALT with outputs quiet
                    state_r      <= ST_HALT;
                    error_r      <= 1'b1;
                    halted_r     <= 1'b1;
                    busy_r       <= 1'b0;
                    instr_req_r  <= 1'b0;
                    mem_read_r   <= 1'b0;
                    reg_write_r  <= 1'b0;
                    mem_reg_r    <= 1'b0;
                    mem_write_r  <= 1'b0;
                    register_1_r <= 6'd0;
                    register_2_r <= 6'd0;
                    offset_r     <= 12'd0;
                    alu_src_r    <= 1'b0;
                    alu_co_r     <= 4'd0;
                end
            endcase
        end
    end

    assign instr_req  = instr_req_r;
    assign instr_addr = pc_r;
    assign register_1 = register_1_r;
    assign register_2 = register_2_r;
    assign offset     = offset_r;
    assign ALUSrc     = alu_src_r;
    assign ALU_CO     = alu_co_r;
    assign RegWrite   = reg_write_r;
    assign MemWrite   = mem_write_r;
    assign MemRead    = mem_read_r;
    assign MemReg     = mem_reg_r;
    assign busy       = busy_r;
    assign halted     = halted_r;
    assign error      = error_r;
    assign retired    = retired_r;

endmodule

// File: tb/tb_ldsd_control_fsm.sv
// Directed testbench for ldsd_control_fsm (default parameters).
module tb_ldsd_control_fsm;

    logic        clk;
    logic        reset;
    logic        start;
    logic        instr_req;
    logic [31:0] instr_addr;
    logic        instr_ack;
    logic [31:0] instr_data;
    logic [5:0]  register_1;
    logic [5:0]  register_2;
    logic [11:0] offset;
    logic        ALUSrc;
    logic [3:0]  ALU_CO;
    logic        RegWrite;
    logic        MemWrite;
    logic        MemRead;
    logic        MemReg;
    logic        busy;
    logic        halted;
    logic        error;
    logic [31:0] retired;

    int checks = 0;
    int errors = 0;

    ldsd_control_fsm dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .instr_req  (instr_req),
        .instr_addr (instr_addr),
        .instr_ack  (instr_ack),
        .instr_data (instr_data),
        .register_1 (register_1),
        .register_2 (register_2),
        .offset     (offset),
        .ALUSrc     (ALUSrc),
        .ALU_CO     (ALU_CO),
        .RegWrite   (RegWrite),
        .MemWrite   (MemWrite),
        .MemRead    (MemRead),
        .MemReg     (MemReg),
        .busy       (busy),
        .halted     (halted),
        .error      (error),
        .retired    (retired)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; inputs change and outputs are sampled 1 ns later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_strobes(input string tag, input logic [3:0] exp_rd_wr_reg_mw);
        check(tag, {60'd0, MemRead, RegWrite, MemReg, MemWrite}, {60'd0, exp_rd_wr_reg_mw});
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        instr_ack  = 1'b0;
        instr_data = 32'd0;

        // 1. Reset for two cycles
        step();
        step();
        check("rst_req",     {63'd0, instr_req}, 64'd0);
        check("rst_addr",    {32'd0, instr_addr}, 64'd0);
        check("rst_ops",     {32'd0, register_1, register_2, offset, ALUSrc, ALU_CO}, 64'd0);
        check_strobes("rst_strobes", 4'b0000);
        check("rst_status",  {61'd0, busy, halted, error}, 64'd0);
        check("rst_retired", {32'd0, retired}, 64'd0);

        // start together with ack: ack outside FETCH is ignored
        reset      = 1'b0;
        start      = 1'b1;
        instr_ack  = 1'b1;
        instr_data = 32'h0081_3283;   // LD x5,8(x2)
        step();
        check("start_req",  {63'd0, instr_req}, 64'd1);
        check("start_busy", {63'd0, busy}, 64'd1);
        check("start_addr", {32'd0, instr_addr}, 64'd0);

        // 2. LD x5,8(x2), ack in first FETCH cycle
        start = 1'b0;
        step();                        // FETCH -> DECODE
        check("ld_dec_req", {63'd0, instr_req}, 64'd0);
        check("ld_dec_ops", {32'd0, register_1, register_2, offset, ALUSrc, ALU_CO}, 64'd0);
        instr_ack = 1'b0;
        step();                        // DECODE -> EXEC
        check("ld_exec_r1",  {58'd0, register_1}, 64'd2);
        check("ld_exec_r2",  {58'd0, register_2}, 64'd5);
        check("ld_exec_off", {52'd0, offset}, 64'h008);
        check("ld_exec_alu", {59'd0, ALUSrc, ALU_CO}, {59'd0, 1'b1, 4'b0010});
        check_strobes("ld_exec_strobes", 4'b0000);
        step();                        // EXEC -> MEM
        check_strobes("ld_mem_strobes", 4'b1110);
        check("ld_mem_r1", {58'd0, register_1}, 64'd2);
        check("ld_mem_retired", {32'd0, retired}, 64'd0);
        instr_ack  = 1'b1;
        instr_data = 32'h0061_B823;   // SD x6,16(x3)
        step();                        // MEM -> FETCH
        check_strobes("ld_post_strobes", 4'b0000);
        check("ld_post_pc",      {32'd0, instr_addr}, 64'd4);
        check("ld_post_retired", {32'd0, retired}, 64'd1);
        check("ld_post_req",     {63'd0, instr_req}, 64'd1);
        check("ld_post_ops",     {32'd0, register_1, register_2, offset, ALUSrc, ALU_CO}, 64'd0);

        // 3. SD x6,16(x3)
        step();                        // FETCH -> DECODE
        instr_ack = 1'b0;
        step();                        // DECODE -> EXEC
        check("sd_exec_r1",  {58'd0, register_1}, 64'd3);
        check("sd_exec_r2",  {58'd0, register_2}, 64'd6);
        check("sd_exec_off", {52'd0, offset}, 64'h010);
        step();                        // EXEC -> MEM
        check_strobes("sd_mem_strobes", 4'b0001);
        instr_ack  = 1'b1;
        instr_data = 32'h0081_3283;
        step();                        // MEM -> FETCH
        check_strobes("sd_post_strobes", 4'b0000);
        check("sd_post_pc",      {32'd0, instr_addr}, 64'd8);
        check("sd_post_retired", {32'd0, retired}, 64'd2);

        // 6. Reset in the MEM cycle of an LD
        step();                        // FETCH -> DECODE
        instr_ack = 1'b0;
        step();                        // DECODE -> EXEC
        step();                        // EXEC -> MEM
        check_strobes("rmem_mem_strobes", 4'b1110);
        reset = 1'b1;
        step();
        check_strobes("rmem_strobes", 4'b0000);
        check("rmem_pc",      {32'd0, instr_addr}, 64'd0);
        check("rmem_retired", {32'd0, retired}, 64'd0);
        check("rmem_status",  {60'd0, instr_req, busy, halted, error}, 64'd0);

        // 4. LD x1,-8(x4), then fetch timeout
        reset      = 1'b0;
        start      = 1'b1;
        step();                        // IDLE -> FETCH
        start      = 1'b0;
        instr_ack  = 1'b1;
        instr_data = 32'hFF82_3083;
        step();                        // FETCH -> DECODE
        instr_ack  = 1'b0;
        step();                        // DECODE -> EXEC
        check("neg_exec_off", {52'd0, offset}, 64'hFF8);
        check("neg_exec_r12", {52'd0, register_1, register_2}, {52'd0, 6'd4, 6'd1});
        step();                        // EXEC -> MEM
        step();                        // MEM -> FETCH, wait count 0
        check("neg_post_pc", {32'd0, instr_addr}, 64'd4);
        for (int i = 0; i < 15; i++) begin
            step();
        end
        check("to_15_status", {60'd0, instr_req, busy, halted, error}, {60'd0, 4'b1100});
        step();
        check("to_16_status", {60'd0, instr_req, busy, halted, error}, {60'd0, 4'b0011});
        check("to_16_retired", {32'd0, retired}, 64'd1);
        // HALT ignores start and ack
        start      = 1'b1;
        instr_ack  = 1'b1;
        instr_data = 32'h0081_3283;
        step();
        step();
        check("halt_sticky", {60'd0, instr_req, busy, halted, error}, {60'd0, 4'b0011});
        start     = 1'b0;
        instr_ack = 1'b0;

        // 5. Illegal instruction (addi)
        reset = 1'b1;
        step();
        check("ill_rst_err", {62'd0, halted, error}, 64'd0);
        reset      = 1'b0;
        start      = 1'b1;
        instr_ack  = 1'b1;
        instr_data = 32'h0000_0013;
        step();                        // IDLE -> FETCH
        start = 1'b0;
        step();                        // FETCH -> DECODE
        instr_ack = 1'b0;
        step();                        // DECODE -> illegal handling
`ifdef SKIP_ILLEGAL_EN
        check("ill_status",  {60'd0, instr_req, busy, halted, error}, {60'd0, 4'b1101});
        check("ill_pc",      {32'd0, instr_addr}, 64'd4);
`else
        check("ill_status",  {60'd0, instr_req, busy, halted, error}, {60'd0, 4'b0011});
        check("ill_pc",      {32'd0, instr_addr}, 64'd0);
`endif
        check("ill_retired", {32'd0, retired}, 64'd0);
        check_strobes("ill_strobes", 4'b0000);

        // All-zero instruction always halts
        reset = 1'b1;
        step();
        reset      = 1'b0;
        start      = 1'b1;
        instr_ack  = 1'b1;
        instr_data = 32'h0000_0000;
        step();
        start = 1'b0;
        step();
        instr_ack = 1'b0;
        step();
        check("zero_status", {60'd0, instr_req, busy, halted, error}, {60'd0, 4'b0011});
        check("zero_pc",     {32'd0, instr_addr}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
